// File: rtl/pipeline_control_regs_p.sv
// pipeline_control_regs_p
// Carries decode-stage control fields through the D/E, E/M and M/W pipeline
// registers. Each stage has a valid bit. The E stage can hold (stall_e), and
// both the D/E and E/M registers can be flushed to a bubble.
// Optional feature: define FORWARD_SEL_EN to add the forward_a_e/forward_b_e
// operand-forwarding selects, which are computed from the E/M and M/W registers.
module pipeline_control_regs_p #(
    parameter int REG_ADR_W = 3,
    parameter int ALU_CON_W = 8,
    parameter int OFFSET_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_d,
    input  logic                 stall_e,
    input  logic                 flush_e,
    input  logic                 flush_m,
    input  logic                 reg_write_d,
    input  logic                 mem_to_reg_d,
    input  logic                 mem_write_d,
    input  logic                 alu_source2_d,
    input  logic [REG_ADR_W-1:0] reg_write_adr_d,
    input  logic [REG_ADR_W-1:0] reg_read_adr1_d,
    input  logic [REG_ADR_W-1:0] reg_read_adr2_d,
    input  logic [ALU_CON_W-1:0] alu_con_d,
    input  logic [OFFSET_W-1:0]  offset_register_d,
    output logic                 valid_e,
    output logic                 reg_write_e,
    output logic                 mem_to_reg_e,
    output logic                 mem_write_e,
    output logic                 alu_source2_e,
    output logic [REG_ADR_W-1:0] reg_write_adr_e,
    output logic [REG_ADR_W-1:0] reg_read_adr1_e,
    output logic [REG_ADR_W-1:0] reg_read_adr2_e,
    output logic [ALU_CON_W-1:0] alu_con_e,
    output logic [OFFSET_W-1:0]  offset_register_e,
    output logic                 valid_m,
    output logic                 reg_write_m,
    output logic                 mem_to_reg_m,
    output logic                 mem_write_m,
    output logic [REG_ADR_W-1:0] reg_write_adr_m,
    output logic                 valid_w,
    output logic                 reg_write_w,
    output logic                 mem_to_reg_w,
    output logic [REG_ADR_W-1:0] reg_write_adr_w
`ifdef FORWARD_SEL_EN
    ,
    output logic [1:0]           forward_a_e,
    output logic [1:0]           forward_b_e
`endif
);

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_to_reg;
        logic                 mem_write;
        logic                 alu_source2;
        logic [REG_ADR_W-1:0] reg_write_adr;
        logic [REG_ADR_W-1:0] reg_read_adr1;
        logic [REG_ADR_W-1:0] reg_read_adr2;
        logic [ALU_CON_W-1:0] alu_con;
        logic [OFFSET_W-1:0]  offset_register;
    } de_t;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_to_reg;
        logic                 mem_write;
        logic [REG_ADR_W-1:0] reg_write_adr;
    } em_t;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_to_reg;
        logic [REG_ADR_W-1:0] reg_write_adr;
    } mw_t;

    de_t d_slot;
    de_t de_q;
    em_t em_q;
    mw_t mw_q;

    // Gather the decode-stage inputs into one slot.
    always_comb begin
        d_slot = '{
            valid:           valid_d,
            reg_write:       reg_write_d,
            mem_to_reg:      mem_to_reg_d,
            mem_write:       mem_write_d,
            alu_source2:     alu_source2_d,
            reg_write_adr:   reg_write_adr_d,
            reg_read_adr1:   reg_read_adr1_d,
            reg_read_adr2:   reg_read_adr2_d,
            alu_con:         alu_con_d,
            offset_register: offset_register_d
        };
    end

    // D/E register: reset and flush take priority over stall (hold), which takes priority over load.
    // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge value of its source.
    always_ff @(posedge clock) begin
        if (reset || flush_e) begin
            de_q <= '0;
        end else if (!stall_e) begin
            de_q <= d_slot;
        end
    end

    // E/M register: a stall or flush inserts a bubble. Write strobes are gated with the source valid bit.
    always_ff @(posedge clock) begin
        if (reset || flush_m || stall_e) begin
            em_q <= '0;
        end else begin
            em_q <= '{
                valid:         de_q.valid,
                reg_write:     de_q.reg_write & de_q.valid,
                mem_to_reg:    de_q.mem_to_reg,
                mem_write:     de_q.mem_write & de_q.valid,
                reg_write_adr: de_q.reg_write_adr
            };
        end
    end

    // M/W register: always advances, except on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            mw_q <= '0;
        end else begin
            mw_q <= '{
                valid:         em_q.valid,
                reg_write:     em_q.reg_write & em_q.valid,
                mem_to_reg:    em_q.mem_to_reg,
                reg_write_adr: em_q.reg_write_adr
            };
        end
    end

    assign valid_e           = de_q.valid;
    assign reg_write_e       = de_q.reg_write;
    assign mem_to_reg_e      = de_q.mem_to_reg;
    assign mem_write_e       = de_q.mem_write;
    assign alu_source2_e     = de_q.alu_source2;
    assign reg_write_adr_e   = de_q.reg_write_adr;
    assign reg_read_adr1_e   = de_q.reg_read_adr1;
    assign reg_read_adr2_e   = de_q.reg_read_adr2;
    assign alu_con_e         = de_q.alu_con;
    assign offset_register_e = de_q.offset_register;

    assign valid_m           = em_q.valid;
    assign reg_write_m       = em_q.reg_write;
    assign mem_to_reg_m      = em_q.mem_to_reg;
    assign mem_write_m       = em_q.mem_write;
    assign reg_write_adr_m   = em_q.reg_write_adr;

    assign valid_w           = mw_q.valid;
    assign reg_write_w       = mw_q.reg_write;
    assign mem_to_reg_w      = mw_q.mem_to_reg;
    assign reg_write_adr_w   = mw_q.reg_write_adr;

`ifdef FORWARD_SEL_EN
    // Forwarding selects: a match in M (the younger result) beats a match in W.
    // NOTE: each output gets a default first, so no path through the block can infer a latch.
    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (em_q.valid && em_q.reg_write && (em_q.reg_write_adr == de_q.reg_read_adr1)) begin
            forward_a_e = 2'b10;
        end else if (mw_q.valid && mw_q.reg_write && (mw_q.reg_write_adr == de_q.reg_read_adr1)) begin
            forward_a_e = 2'b01;
        end
        if (em_q.valid && em_q.reg_write && (em_q.reg_write_adr == de_q.reg_read_adr2)) begin
            forward_b_e = 2'b10;
        end else if (mw_q.valid && mw_q.reg_write && (mw_q.reg_write_adr == de_q.reg_read_adr2)) begin
            forward_b_e = 2'b01;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_control_regs_p.sv
// Testbench for pipeline_control_regs_p: directed vector table, hand-written
// corner sequences, and randomized traffic checked against an instruction-level model.
module tb_pipeline_control_regs_p;

    logic       clock = 1'b0;
    logic       reset;
    logic       valid_d, stall_e, flush_e, flush_m;
    logic       reg_write_d, mem_to_reg_d, mem_write_d, alu_source2_d;
    logic [2:0] reg_write_adr_d, reg_read_adr1_d, reg_read_adr2_d;
    logic [7:0] alu_con_d;
    logic [15:0] offset_register_d;
    logic       valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_source2_e;
    logic [2:0] reg_write_adr_e, reg_read_adr1_e, reg_read_adr2_e;
    logic [7:0] alu_con_e;
    logic [15:0] offset_register_e;
    logic       valid_m, reg_write_m, mem_to_reg_m, mem_write_m;
    logic [2:0] reg_write_adr_m;
    logic       valid_w, reg_write_w, mem_to_reg_w;
    logic [2:0] reg_write_adr_w;
`ifdef FORWARD_SEL_EN
    logic [1:0] forward_a_e, forward_b_e;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipeline_control_regs_p dut (
        .clock(clock), .reset(reset), .valid_d(valid_d), .stall_e(stall_e),
        .flush_e(flush_e), .flush_m(flush_m),
        .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d),
        .mem_write_d(mem_write_d), .alu_source2_d(alu_source2_d),
        .reg_write_adr_d(reg_write_adr_d), .reg_read_adr1_d(reg_read_adr1_d),
        .reg_read_adr2_d(reg_read_adr2_d), .alu_con_d(alu_con_d),
        .offset_register_d(offset_register_d),
        .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
        .mem_write_e(mem_write_e), .alu_source2_e(alu_source2_e),
        .reg_write_adr_e(reg_write_adr_e), .reg_read_adr1_e(reg_read_adr1_e),
        .reg_read_adr2_e(reg_read_adr2_e), .alu_con_e(alu_con_e),
        .offset_register_e(offset_register_e),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
        .mem_write_m(mem_write_m), .reg_write_adr_m(reg_write_adr_m),
        .valid_w(valid_w), .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w),
        .reg_write_adr_w(reg_write_adr_w)
`ifdef FORWARD_SEL_EN
        , .forward_a_e(forward_a_e), .forward_b_e(forward_b_e)
`endif
    );

    // One whole instruction as it leaves decode.
    typedef struct {
        bit        valid, rw, m2r, mw, as2;
        bit [2:0]  wadr, r1, r2;
        bit [7:0]  alu;
        bit [15:0] off;
    } instr_t;

    // Directed vector: controls, D inputs, then the expected E/M/W view after the edge.
    typedef struct {
        bit       rst, stall, fe, fm;
        bit       v, rw;
        bit [2:0] adr;
        bit [7:0] alu;
        bit       ev, erw;
        bit [7:0] ealu;
        bit       mv, mrw;
        bit [2:0] madr;
        bit       wv, wrw;
        bit [2:0] wadr;
    } vec_t;

    // Instruction-level model: the instruction currently occupying each stage.
    instr_t e_s, m_s, w_s;
    instr_t bubble;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input instr_t i);
        valid_d           = i.valid;
        reg_write_d       = i.rw;
        mem_to_reg_d      = i.m2r;
        mem_write_d       = i.mw;
        alu_source2_d     = i.as2;
        reg_write_adr_d   = i.wadr;
        reg_read_adr1_d   = i.r1;
        reg_read_adr2_d   = i.r2;
        alu_con_d         = i.alu;
        offset_register_d = i.off;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance the model by one edge, given the current control inputs and D instruction.
    task automatic model_step(input bit rst, input bit st, input bit fe, input bit fm, input instr_t d);
        if (rst) begin
            e_s = bubble; m_s = bubble; w_s = bubble;
        end else begin
            w_s = m_s;
            m_s = (fm || st) ? bubble : e_s;
            if (fe)       e_s = bubble;
            else if (!st) e_s = d;
        end
    endtask

    // Compare every DUT output with the stage views of the model's instructions.
    task automatic check_model(input int cyc);
        bit m_wr, w_wr;
        m_wr = m_s.valid & m_s.rw;
        w_wr = w_s.valid & w_s.rw;
        check($sformatf("rnd%0d valid_e", cyc), valid_e, e_s.valid);
        check($sformatf("rnd%0d reg_write_e", cyc), reg_write_e, e_s.rw);
        check($sformatf("rnd%0d mem_to_reg_e", cyc), mem_to_reg_e, e_s.m2r);
        check($sformatf("rnd%0d mem_write_e", cyc), mem_write_e, e_s.mw);
        check($sformatf("rnd%0d alu_source2_e", cyc), alu_source2_e, e_s.as2);
        check($sformatf("rnd%0d adrs_e", cyc), {reg_write_adr_e, reg_read_adr1_e, reg_read_adr2_e},
              {e_s.wadr, e_s.r1, e_s.r2});
        check($sformatf("rnd%0d alu_con_e", cyc), alu_con_e, e_s.alu);
        check($sformatf("rnd%0d offset_e", cyc), offset_register_e, e_s.off);
        check($sformatf("rnd%0d m_stage", cyc),
              {valid_m, reg_write_m, mem_to_reg_m, mem_write_m, reg_write_adr_m},
              {m_s.valid, m_wr, m_s.m2r, m_s.valid & m_s.mw, m_s.wadr});
        check($sformatf("rnd%0d w_stage", cyc),
              {valid_w, reg_write_w, mem_to_reg_w, reg_write_adr_w},
              {w_s.valid, w_wr, w_s.m2r, w_s.wadr});
`ifdef FORWARD_SEL_EN
        begin
            logic [1:0] fa, fb;
            fa = (m_wr && m_s.wadr == e_s.r1) ? 2'b10 : (w_wr && w_s.wadr == e_s.r1) ? 2'b01 : 2'b00;
            fb = (m_wr && m_s.wadr == e_s.r2) ? 2'b10 : (w_wr && w_s.wadr == e_s.r2) ? 2'b01 : 2'b00;
            check($sformatf("rnd%0d forward_a_e", cyc), forward_a_e, fa);
            check($sformatf("rnd%0d forward_b_e", cyc), forward_b_e, fb);
        end
`endif
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid = 1'($urandom_range(0, 3) != 0);
        i.rw    = 1'($urandom);
        i.m2r   = 1'($urandom);
        i.mw    = 1'($urandom);
        i.as2   = 1'($urandom);
        i.wadr  = 3'($urandom);
        i.r1    = 3'($urandom);
        i.r2    = 3'($urandom);
        i.alu   = 8'($urandom);
        i.off   = 16'($urandom);
        return i;
    endfunction

    vec_t   tbl [16];
    instr_t ins;

    initial begin
        bubble = '{default: 0};
        tbl[0]  = '{0,0,0,0, 1,1,3'd5,8'h11, 1,1,8'h11, 0,0,3'd0, 0,0,3'd0};
        tbl[1]  = '{0,0,0,0, 0,0,3'd0,8'h00, 0,0,8'h00, 1,1,3'd5, 0,0,3'd0};
        tbl[2]  = '{0,0,0,0, 0,0,3'd0,8'h00, 0,0,8'h00, 0,0,3'd0, 1,1,3'd5};
        tbl[3]  = '{0,0,0,0, 0,0,3'd0,8'h00, 0,0,8'h00, 0,0,3'd0, 0,0,3'd0};
        tbl[4]  = '{0,0,0,0, 1,1,3'd2,8'hA5, 1,1,8'hA5, 0,0,3'd0, 0,0,3'd0};
        tbl[5]  = '{0,1,0,0, 1,1,3'd6,8'h3C, 1,1,8'hA5, 0,0,3'd0, 0,0,3'd0};
        tbl[6]  = '{0,1,0,0, 1,1,3'd6,8'h3C, 1,1,8'hA5, 0,0,3'd0, 0,0,3'd0};
        tbl[7]  = '{0,0,0,0, 1,1,3'd6,8'h3C, 1,1,8'h3C, 1,1,3'd2, 0,0,3'd0};
        tbl[8]  = '{0,0,0,1, 1,1,3'd7,8'h77, 1,1,8'h77, 0,0,3'd0, 1,1,3'd2};
        tbl[9]  = '{0,0,0,0, 0,0,3'd0,8'h00, 0,0,8'h00, 1,1,3'd7, 0,0,3'd0};
        tbl[10] = '{0,1,1,0, 1,1,3'd1,8'h99, 0,0,8'h00, 0,0,3'd0, 1,1,3'd7};
        tbl[11] = '{0,0,0,0, 0,0,3'd0,8'h00, 0,0,8'h00, 0,0,3'd0, 0,0,3'd0};
        tbl[12] = '{0,0,0,0, 0,1,3'd3,8'h44, 0,1,8'h44, 0,0,3'd0, 0,0,3'd0};
        tbl[13] = '{0,0,0,0, 0,0,3'd0,8'h00, 0,0,8'h00, 0,0,3'd3, 0,0,3'd0};
        tbl[14] = '{0,0,0,0, 1,1,3'd4,8'h55, 1,1,8'h55, 0,0,3'd0, 0,0,3'd3};
        tbl[15] = '{1,1,0,0, 1,1,3'd7,8'hFF, 0,0,8'h00, 0,0,3'd0, 0,0,3'd0};

        // Reset with every D input at all-ones: all outputs must stay zero.
        reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0; flush_m = 1'b0;
        ins = '{1, 1, 1, 1, 1, 3'h7, 3'h7, 3'h7, 8'hFF, 16'hFFFF};
        drive(ins);
        tick(); tick();
        check("reset e_ctl", {valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_source2_e}, 0);
        check("reset e_data", {reg_write_adr_e, reg_read_adr1_e, reg_read_adr2_e, alu_con_e, offset_register_e}, 0);
        check("reset m", {valid_m, reg_write_m, mem_to_reg_m, mem_write_m, reg_write_adr_m}, 0);
        check("reset w", {valid_w, reg_write_w, mem_to_reg_w, reg_write_adr_w}, 0);
        reset = 1'b0;
        tick();
        check("post_reset e_ctl", {valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_source2_e}, 5'h1F);
        check("post_reset e_data", {reg_write_adr_e, reg_read_adr1_e, reg_read_adr2_e, alu_con_e, offset_register_e},
              {3'h7, 3'h7, 3'h7, 8'hFF, 16'hFFFF});

        // Directed vector table, starting from an empty pipeline.
        reset = 1'b1; drive(bubble); tick(); reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            reset = tbl[i].rst; stall_e = tbl[i].stall; flush_e = tbl[i].fe; flush_m = tbl[i].fm;
            ins = bubble;
            ins.valid = tbl[i].v; ins.rw = tbl[i].rw; ins.wadr = tbl[i].adr; ins.alu = tbl[i].alu;
            drive(ins);
            tick();
            check($sformatf("vec%0d e", i), {valid_e, reg_write_e, alu_con_e}, {tbl[i].ev, tbl[i].erw, tbl[i].ealu});
            check($sformatf("vec%0d m", i), {valid_m, reg_write_m, reg_write_adr_m}, {tbl[i].mv, tbl[i].mrw, tbl[i].madr});
            check($sformatf("vec%0d w", i), {valid_w, reg_write_w, reg_write_adr_w}, {tbl[i].wv, tbl[i].wrw, tbl[i].wadr});
        end
        reset = 1'b0; stall_e = 1'b0;

        // flush_e and stall_e together on a valid store: it must never reach memory.
        drive(bubble); tick();
        ins = bubble; ins.valid = 1'b1; ins.mw = 1'b1;
        drive(ins); flush_e = 1'b1; stall_e = 1'b1;
        tick();
        check("flush_pri e", {valid_e, mem_write_e}, 2'b00);
        check("flush_pri m", valid_m, 1'b0);
        flush_e = 1'b0; stall_e = 1'b0; drive(bubble);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("flush_pri mem_write_m%0d", k), mem_write_m, 1'b0);
        end

`ifdef FORWARD_SEL_EN
        // Two writers of r3 in flight, then a reader of r3/r4 in E.
        ins = bubble; ins.valid = 1'b1; ins.rw = 1'b1; ins.wadr = 3'd3;
        drive(ins); tick(); tick();
        ins = bubble; ins.valid = 1'b1; ins.r1 = 3'd3; ins.r2 = 3'd4;
        drive(ins); tick();
        check("fwd m_match a", forward_a_e, 2'b10);
        check("fwd none b", forward_b_e, 2'b00);
        stall_e = 1'b1; tick(); stall_e = 1'b0;
        check("fwd w_match a", forward_a_e, 2'b01);
        check("fwd none b2", forward_b_e, 2'b00);
`endif

        // Randomized traffic against the instruction-level model.
        reset = 1'b1; drive(bubble);
        model_step(1'b1, 1'b0, 1'b0, 1'b0, bubble);
        tick();
        check_model(-1);
        for (int c = 0; c < 400; c++) begin
            ins     = rand_instr();
            reset   = ($urandom_range(0, 39) == 0);
            stall_e = ($urandom_range(0, 4) == 0);
            flush_e = ($urandom_range(0, 7) == 0);
            flush_m = ($urandom_range(0, 7) == 0);
            drive(ins);
            model_step(reset, stall_e, flush_e, flush_m, ins);
            tick();
            check_model(c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
